fetch_redirect_ctrl: RTL

Fetch-side PC controller and branch-resolution unit for the 5-bit word-addressed pipeline. Owns the fetch PC register, consumes the branch predictor's `F_BP_taken`/`F_BP_target_pc`, and carries each prediction alongside its instruction through F→D→EX. In EX it checks the prediction against the resolved outcome, then issues a redirect and D/EX flush on mismatch. Provides the EX-side PC and branch strobe that update the predictor, and keeps saturating prediction statistics.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/bp_meta_stage.sv | 36 +++
 rtl/fetch_redirect_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch/redirect slice: PC width, statistics width, per-stage prediction metadata.
// Pure definitions; no timing or flow-control behaviour of its own.
package fetch_pkg;

    localparam int PC_W  = 5;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } bp_meta_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/bp_meta_stage.sv
// One pipeline slot of prediction metadata; one-cycle register latency.
// kill clears valid and beats load; with neither asserted the entry holds.
module bp_meta_stage
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     kill,
    input  bp_meta_t meta_in,
    output bp_meta_t meta_out
);

    bp_meta_t meta_q;
    bp_meta_t meta_d;

    always_comb begin
        meta_d = meta_q;
        if (kill) begin
            meta_d.valid = 1'b0;
        end else if (load) begin
            meta_d = meta_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
        end else begin
            meta_q <= meta_d;
        end
    end

    assign meta_out = meta_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner plus EX-stage branch check; predictions reach EX two cycles after fetch, redirect lands next cycle.
// F_stall holds PC and D and bubbles EX; a mispredict overrides the stall.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int CNT_W = fetch_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             F_stall,
    input  logic             F_BP_taken,
    input  logic [PC_W-1:0]  F_BP_target_pc,
    input  logic             EX_is_brn,
    input  logic             EX_true_taken,
    input  logic [PC_W-1:0]  EX_alu_out,
    output logic [PC_W-1:0]  F_pc,
    output logic [PC_W-1:0]  EX_pc,
    output logic             EX_brn,
    output logic             EX_mispredict,
    output logic             flush_D,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    logic [PC_W-1:0]  f_pc_q, f_pc_d;
    logic [CNT_W-1:0] stat_br_q, stat_br_d;
    logic [CNT_W-1:0] stat_mp_q, stat_mp_d;
    bp_meta_t         d_in, d_meta, ex_meta;
    logic             ex_taken, mispredict, ex_brn;
    logic [PC_W-1:0]  redirect_pc;

    // A non-branch never redirects to EX_alu_out, whatever EX_true_taken says.
    always_comb begin
        ex_taken   = EX_is_brn & EX_true_taken;
        mispredict = 1'b0;
        if (ex_meta.valid) begin
            if (EX_is_brn) begin
                mispredict = (ex_meta.pred_taken != EX_true_taken) |
                             (EX_true_taken & (ex_meta.pred_target != EX_alu_out));
            end else begin
                mispredict = ex_meta.pred_taken;
            end
        end
        redirect_pc = ex_taken ? EX_alu_out : pc_inc(ex_meta.pc);
        ex_brn      = EX_is_brn & ex_meta.valid;
    end

    always_comb begin
        f_pc_d = pc_inc(f_pc_q);
        if (mispredict) begin
            f_pc_d = redirect_pc;
        end else if (F_stall) begin
            f_pc_d = f_pc_q;
        end else if (F_BP_taken) begin
            f_pc_d = F_BP_target_pc;
        end
    end

    always_comb begin
        d_in.valid       = 1'b1;
        d_in.pc          = f_pc_q;
        d_in.pred_taken  = F_BP_taken;
        d_in.pred_target = F_BP_target_pc;
    end

    bp_meta_stage u_d_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (!F_stall),
        .kill     (mispredict),
        .meta_in  (d_in),
        .meta_out (d_meta)
    );

    bp_meta_stage u_ex_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b1),
        .kill     (mispredict | F_stall),
        .meta_in  (d_meta),
        .meta_out (ex_meta)
    );

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (ex_brn && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + CNT_W'(1);
        end
        if (mispredict && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            f_pc_q    <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            f_pc_q    <= f_pc_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign F_pc             = f_pc_q;
    assign EX_pc            = ex_meta.pc;
    assign EX_brn           = ex_brn;
    assign EX_mispredict    = mispredict;
    assign flush_D          = mispredict;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule
